draw_arbiter: RTL and testbench

Shares the single VGA plot port between the game's drawing requesters: background erase, wall and bird, all driven by their own control FSMs. The block grants one requester at a time in round-robin order and latches that requester's rectangle descriptor. It then rasters the rectangle one pixel per clock onto the plot port and pulses a per-requester done. It sits between the bird and wall controllers and the VGA adapter. It replaces ad-hoc alternation between controller states.

---
 rtl/draw_pkg.sv | 32 +++
 rtl/draw_rr_pick.sv | 30 +++
 rtl/draw_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_draw_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// Shared types and constants for the draw arbiter and its requesters.
package draw_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DRAW = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Visible screen size in pixels
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    // Requester indices
    localparam int NUM_REQ_DEF = 3;
    localparam int REQ_BG      = 0;
    localparam int REQ_WALL    = 1;
    localparam int REQ_BIRD    = 2;

    // 3-bit RGB colours
    localparam logic [2:0] COL_BLACK  = 3'b000;
    localparam logic [2:0] COL_BLUE   = 3'b001;
    localparam logic [2:0] COL_GREEN  = 3'b010;
    localparam logic [2:0] COL_CYAN   = 3'b011;
    localparam logic [2:0] COL_RED    = 3'b100;
    localparam logic [2:0] COL_PURPLE = 3'b101;
    localparam logic [2:0] COL_YELLOW = 3'b110;
    localparam logic [2:0] COL_WHITE  = 3'b111;

endpackage

// File: rtl/draw_rr_pick.sv
// Combinational round-robin picker: searches from the index after the
// last-served requester and returns the first requesting index as one-hot.
module draw_rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] winner,
    output logic               valid
);

    int  idx_s;
    logic hit_s;

    // Rotating priority search; the first hit after 'last' wins
    always_comb begin
        winner = {NUM_REQ{1'b0}};
        valid  = 1'b0;
        idx_s  = 0;
        hit_s  = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx_s = (int'(last) + i) % NUM_REQ;
            hit_s = !valid && req[IDX_W'(idx_s)];
            winner[IDX_W'(idx_s)] = winner[IDX_W'(idx_s)] | hit_s;
            valid = valid | hit_s;
        end
    end

endmodule

// File: rtl/draw_arbiter.sv
// Round-robin arbiter for the VGA plot port: grants one requester, latches
// its rectangle and rasters it one pixel per clock with off-screen clipping.
module draw_arbiter
    import draw_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int X_W     = 8,
    parameter int Y_W     = 7,
    parameter int COL_W   = 3,
    parameter int MAX_X   = SCREEN_W - 1,
    parameter int MAX_Y   = SCREEN_H - 1
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*X_W-1:0]   req_x,
    input  logic [NUM_REQ*Y_W-1:0]   req_y,
    input  logic [NUM_REQ*X_W-1:0]   req_w,
    input  logic [NUM_REQ*Y_W-1:0]   req_h,
    input  logic [NUM_REQ*COL_W-1:0] req_col,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       done,
    output logic                     plot,
    output logic [X_W-1:0]           plot_x,
    output logic [Y_W-1:0]           plot_y,
    output logic [COL_W-1:0]         plot_col,
    output logic                     busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t               state_r;
    logic [IDX_W-1:0]     last_r;
    logic [IDX_W-1:0]     win_idx_r;
    logic [NUM_REQ-1:0]   grant_r;
    logic [NUM_REQ-1:0]   done_r;
    logic                 plot_r;
    logic [X_W-1:0]       plot_x_r;
    logic [Y_W-1:0]       plot_y_r;
    logic [COL_W-1:0]     plot_col_r;
    logic                 busy_r;

    // Latched descriptor and raster counters (cx/cy = pixel on the port now)
    logic [X_W-1:0]       x_r, w_r, cx_r;
    logic [Y_W-1:0]       y_r, h_r, cy_r;
    logic [COL_W-1:0]     col_r;

    logic [NUM_REQ-1:0]   pick_winner_s;
    logic                 pick_valid_s;
    logic [IDX_W-1:0]     win_idx_s;

    logic [X_W-1:0]       x_arr_s   [NUM_REQ];
    logic [Y_W-1:0]       y_arr_s   [NUM_REQ];
    logic [X_W-1:0]       w_arr_s   [NUM_REQ];
    logic [Y_W-1:0]       h_arr_s   [NUM_REQ];
    logic [COL_W-1:0]     col_arr_s [NUM_REQ];

    logic                 last_col_s;
    logic                 last_pix_s;
    logic [X_W-1:0]       emit_cx_s;
    logic [Y_W-1:0]       emit_cy_s;
    logic [X_W:0]         sum_x_s;
    logic [Y_W:0]         sum_y_s;
    logic                 vis_s;

    assign grant    = grant_r;
    assign done     = done_r;
    assign plot     = plot_r;
    assign plot_x   = plot_x_r;
    assign plot_y   = plot_y_r;
    assign plot_col = plot_col_r;
    assign busy     = busy_r;

    // Split the flat descriptor buses into per-requester fields
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign x_arr_s[g]   = req_x[g*X_W +: X_W];
        assign y_arr_s[g]   = req_y[g*Y_W +: Y_W];
        assign w_arr_s[g]   = req_w[g*X_W +: X_W];
        assign h_arr_s[g]   = req_h[g*Y_W +: Y_W];
        assign col_arr_s[g] = req_col[g*COL_W +: COL_W];
    end

    draw_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req    (req),
        .last   (last_r),
        .winner (pick_winner_s),
        .valid  (pick_valid_s)
    );

    // Encode the one-hot winner as an index for descriptor selection
    always_comb begin
        win_idx_s = {IDX_W{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            win_idx_s = win_idx_s | (pick_winner_s[i] ? IDX_W'(i) : {IDX_W{1'b0}});
        end
    end

    // Next pixel position and its on-screen visibility (sums kept one bit wider)
    always_comb begin
        last_col_s = (cx_r == (w_r - X_W'(1)));
        last_pix_s = last_col_s && (cy_r == (h_r - Y_W'(1)));
        if (state_r == ST_LOAD) begin
            emit_cx_s = {X_W{1'b0}};
            emit_cy_s = {Y_W{1'b0}};
        end else if (last_col_s) begin
            emit_cx_s = {X_W{1'b0}};
            emit_cy_s = cy_r + Y_W'(1);
        end else begin
            emit_cx_s = cx_r + X_W'(1);
            emit_cy_s = cy_r;
        end
        sum_x_s = {1'b0, x_r} + {1'b0, emit_cx_s};
        sum_y_s = {1'b0, y_r} + {1'b0, emit_cy_s};
        vis_s   = (sum_x_s <= (X_W+1)'(MAX_X)) && (sum_y_s <= (Y_W+1)'(MAX_Y));
    end

    // Arbiter FSM with registered grant/done/plot outputs
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r    <= ST_IDLE;
            last_r     <= IDX_W'(NUM_REQ - 1);
            win_idx_r  <= {IDX_W{1'b0}};
            grant_r    <= {NUM_REQ{1'b0}};
            done_r     <= {NUM_REQ{1'b0}};
            plot_r     <= 1'b0;
            plot_x_r   <= {X_W{1'b0}};
            plot_y_r   <= {Y_W{1'b0}};
            plot_col_r <= {COL_W{1'b0}};
            busy_r     <= 1'b0;
            x_r        <= {X_W{1'b0}};
            y_r        <= {Y_W{1'b0}};
            w_r        <= {X_W{1'b0}};
            h_r        <= {Y_W{1'b0}};
            col_r      <= {COL_W{1'b0}};
            cx_r       <= {X_W{1'b0}};
            cy_r       <= {Y_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    plot_r <= 1'b0;
                    done_r <= {NUM_REQ{1'b0}};
                    if (pick_valid_s) begin
                        state_r   <= ST_LOAD;
                        grant_r   <= pick_winner_s;
                        busy_r    <= 1'b1;
                        win_idx_r <= win_idx_s;
                        x_r       <= x_arr_s[win_idx_s];
                        y_r       <= y_arr_s[win_idx_s];
                        w_r       <= w_arr_s[win_idx_s];
                        h_r       <= h_arr_s[win_idx_s];
                        col_r     <= col_arr_s[win_idx_s];
                        cx_r      <= {X_W{1'b0}};
                        cy_r      <= {Y_W{1'b0}};
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    if ((w_r == {X_W{1'b0}}) || (h_r == {Y_W{1'b0}})) begin
                        state_r <= ST_DONE;
                        done_r  <= grant_r;
                        plot_r  <= 1'b0;
                    end else begin
                        state_r    <= ST_DRAW;
                        plot_r     <= vis_s;
                        plot_x_r   <= sum_x_s[X_W-1:0];
                        plot_y_r   <= sum_y_s[Y_W-1:0];
                        plot_col_r <= col_r;
                        cx_r       <= emit_cx_s;
                        cy_r       <= emit_cy_s;
                    end
                end
                ST_DRAW: begin
                    if (last_pix_s) begin
                        state_r <= ST_DONE;
                        done_r  <= grant_r;
                        plot_r  <= 1'b0;
                    end else begin
                        plot_r     <= vis_s;
                        plot_x_r   <= sum_x_s[X_W-1:0];
                        plot_y_r   <= sum_y_s[Y_W-1:0];
                        plot_col_r <= col_r;
                        cx_r       <= emit_cx_s;
                        cy_r       <= emit_cy_s;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    done_r  <= {NUM_REQ{1'b0}};
                    grant_r <= {NUM_REQ{1'b0}};
                    busy_r  <= 1'b0;
                    last_r  <= win_idx_r;
                end
                default: begin
                    state_r <= ST_IDLE;
                    done_r  <= {NUM_REQ{1'b0}};
                    grant_r <= {NUM_REQ{1'b0}};
                    plot_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_draw_arbiter.sv
// Self-checking bench for draw_arbiter: directed scenarios plus random
// rounds, checked against a per-rectangle reference model.
module tb_draw_arbiter;
    import draw_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic [2:0]  req;
    logic [23:0] req_x, req_w;
    logic [20:0] req_y, req_h;
    logic [8:0]  req_col;
    logic [2:0]  grant, done;
    logic        plot;
    logic [7:0]  plot_x;
    logic [6:0]  plot_y;
    logic [2:0]  plot_col;
    logic        busy;

    int checks = 0;
    int errors = 0;

    int dx[3], dy[3], dw[3], dh[3], dc[3];
    bit pend[3];
    int ptr;

    draw_arbiter dut (
        .clk(clk), .resetn(resetn), .req(req),
        .req_x(req_x), .req_y(req_y), .req_w(req_w), .req_h(req_h),
        .req_col(req_col), .grant(grant), .done(done), .plot(plot),
        .plot_x(plot_x), .plot_y(plot_y), .plot_col(plot_col), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 3; i++) begin
            req[i]             = pend[i];
            req_x[i*8 +: 8]    = 8'(dx[i]);
            req_y[i*7 +: 7]    = 7'(dy[i]);
            req_w[i*8 +: 8]    = 8'(dw[i]);
            req_h[i*7 +: 7]    = 7'(dh[i]);
            req_col[i*3 +: 3]  = 3'(dc[i]);
        end
    endtask

    function automatic int pick();
        for (int i = 1; i <= 3; i++) begin
            int k;
            k = (ptr + i) % 3;
            if (pend[k]) return k;
        end
        return -1;
    endfunction

    task automatic set_desc(input int i, input int x, input int y, input int w, input int h, input int c);
        dx[i] = x; dy[i] = y; dw[i] = w; dh[i] = h; dc[i] = c;
    endtask

    // Called at a negedge with the DUT idle and requests driven; follows one
    // rectangle from grant to return-to-idle.
    task automatic serve(input bit keep, input bit mutate);
        int w, ex, ey, ew, eh, ec, npix, sx, sy;
        logic [2:0] oh;
        w = pick();
        if (w < 0) begin
            chk("pick_none", 32'd0, 32'd1);
            return;
        end
        ex = dx[w]; ey = dy[w]; ew = dw[w]; eh = dh[w]; ec = dc[w];
        npix = ew * eh;
        oh = 3'(1 << w);
        @(negedge clk);
        chk("load_grant", grant, oh);
        chk("load_busy", busy, 1);
        chk("load_plot", plot, 0);
        chk("load_done", done, 0);
        for (int k = 0; k < npix; k++) begin
            if (mutate && k == 1) begin
                dx[w] = dx[w] + 37;
                dw[w] = dw[w] + 1;
                pend[w] = 1'b0;
                drive();
            end
            @(negedge clk);
            sx = ex + (k % ew);
            sy = ey + (k / ew);
            chk("draw_plot", plot, (sx <= 159 && sy <= 119) ? 1 : 0);
            chk("draw_x", plot_x, sx % 256);
            chk("draw_y", plot_y, sy % 128);
            chk("draw_col", plot_col, ec);
            chk("draw_grant", grant, oh);
        end
        @(negedge clk);
        chk("done_pulse", done, oh);
        chk("done_plot", plot, 0);
        chk("done_grant", grant, oh);
        chk("done_busy", busy, 1);
        if (!keep) pend[w] = 1'b0;
        drive();
        ptr = w;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_grant", grant, 0);
        chk("idle_done", done, 0);
    endtask

    initial begin
        resetn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pend[i] = 1'b0;
            set_desc(i, 0, 0, 0, 0, 0);
        end
        ptr = 2;
        drive();
        repeat (3) @(negedge clk);
        chk("rst_grant", grant, 0);
        chk("rst_done", done, 0);
        chk("rst_plot", plot, 0);
        chk("rst_plot_x", plot_x, 0);
        chk("rst_plot_y", plot_y, 0);
        chk("rst_plot_col", plot_col, 0);
        chk("rst_busy", busy, 0);
        resetn = 1'b1;

        // Single request from the wall controller
        set_desc(REQ_WALL, 10, 20, 2, 2, 3);
        pend[REQ_WALL] = 1'b1;
        drive();
        serve(1'b0, 1'b0);

        // Round-robin with all requests held; reset first so requester 0 leads
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        ptr = 2;
        set_desc(0, 1, 1, 2, 1, 1);
        set_desc(1, 5, 5, 1, 2, 2);
        set_desc(2, 9, 9, 2, 1, 4);
        for (int i = 0; i < 3; i++) pend[i] = 1'b1;
        drive();
        for (int r = 0; r < 4; r++) serve(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) pend[i] = 1'b0;
        drive();
        @(negedge clk);
        chk("rr_quiet_busy", busy, 0);

        // Clipping at the bottom-right corner
        set_desc(REQ_BG, 158, 119, 4, 2, 7);
        pend[REQ_BG] = 1'b1;
        drive();
        serve(1'b0, 1'b0);

        // Zero-width rectangle
        set_desc(REQ_BIRD, 5, 5, 0, 5, 6);
        pend[REQ_BIRD] = 1'b1;
        drive();
        serve(1'b0, 1'b0);

        // Descriptor and req change mid-draw
        set_desc(REQ_WALL, 30, 40, 3, 2, 5);
        pend[REQ_WALL] = 1'b1;
        drive();
        serve(1'b0, 1'b1);

        // Reset in the middle of a 4x4 rectangle
        set_desc(0, 2, 2, 1, 1, 1);
        pend[0] = 1'b1;
        drive();
        serve(1'b0, 1'b0);
        set_desc(1, 50, 50, 4, 4, 2);
        pend[1] = 1'b1;
        drive();
        repeat (4) @(negedge clk);
        chk("mid_plot_on", plot, 1);
        resetn = 1'b0;
        pend[0] = 1'b1; pend[1] = 1'b0; pend[2] = 1'b1;
        set_desc(2, 70, 70, 2, 2, 4);
        drive();
        @(negedge clk);
        chk("mid_rst_grant", grant, 0);
        chk("mid_rst_plot", plot, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        resetn = 1'b1;
        ptr = 2;
        chk("mid_rst_model_pick", 32'(pick()), 0);
        serve(1'b0, 1'b0);
        serve(1'b0, 1'b0);

        // Random rounds: several requesters at once, random rectangles
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < 3; i++) begin
                pend[i] = 1'($urandom_range(0, 1));
                set_desc(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
                         int'($urandom_range(0, 6)), int'($urandom_range(0, 5)),
                         int'($urandom_range(0, 7)));
            end
            if (!(pend[0] || pend[1] || pend[2])) pend[$urandom_range(0, 2)] = 1'b1;
            drive();
            while (pend[0] || pend[1] || pend[2]) serve(1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
